// File: rtl/dma_sched_pkg.sv
// dma_sched_pkg: shared types and constants for the DMA job scheduler.
//   - DMA controller register map and AXI widths (shared with the controller RTL)
//   - FSM state and register-index enums
//   - descriptor config field positions, AXI burst/size constants
//   - reg_offset(): register index -> byte offset inside the DMA slave

`ifndef DMA_DEFINES_SV
`define DMA_DEFINES_SV
`define ADDR_WIDTH      32
`define ID_BITS         4
`define LEN_BITS        8
`define SIZE_BITS       3
`define ADDR_ADDR_SRC   32'h0000_0000
`define ADDR_ADDR_DST   32'h0000_0004
`define ADDR_CONFIG_DMA 32'h0000_0008
`define ADDR_VALID      32'h0000_000C
`endif

package dma_sched_pkg;

    localparam int AW     = `ADDR_WIDTH;
    localparam int ID_W   = `ID_BITS;
    localparam int LEN_W  = `LEN_BITS;
    localparam int SIZE_W = `SIZE_BITS;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    localparam int CFG_W         = 13;
    localparam int CFG_BURST_MSB = 12;
    localparam int CFG_BURST_LSB = 11;
    localparam int CFG_SIZE_MSB  = 10;
    localparam int CFG_SIZE_LSB  = 8;
    localparam int CFG_LEN_MSB   = 7;
    localparam int CFG_LEN_LSB   = 0;

    localparam logic [1:0]        AXI_BURST_INCR = 2'b01;
    localparam logic [SIZE_W-1:0] AXI_SIZE_4B    = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_WAIT_IRQ,
        ST_CLEAR
    } state_e;

    typedef enum logic [1:0] {
        REG_SRC,
        REG_DST,
        REG_CFG,
        REG_VALID
    } reg_idx_e;

    function automatic logic [AW-1:0] reg_offset(input reg_idx_e idx);
        case (idx)
            REG_SRC: return `ADDR_ADDR_SRC;
            REG_DST: return `ADDR_ADDR_DST;
            REG_CFG: return `ADDR_CONFIG_DMA;
            default: return `ADDR_VALID;
        endcase
    endfunction

endpackage

// File: rtl/dma_sched_rr_arbiter.sv
// rr_arbiter: round-robin arbiter with an internal rotating pointer.
//   clk_i, rst_ni    clock, async active-low reset
//   req [N]          request vector
//   advance          a grant was taken; pointer moves past the winner
//   gnt [N]          one-hot grant (combinational)
//   gnt_idx          index of the granted requester
//   gnt_valid        at least one request present

module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] jj;
    int            j;

    // Scan from the farthest offset down so the requester closest to the
    // pointer is the one left standing.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        j       = 0;
        jj      = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j  = (int'(ptr_q) + i) % N;
            jj = j[IW-1:0];
            if (req[jj]) begin
                gnt     = '0;
                gnt[jj] = 1'b1;
                gnt_idx = jj;
            end
        end
    end

    assign gnt_valid = |req;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/dma_sched.sv
// dma_sched: round-robin job scheduler in front of the single DMA controller.
// Grants one channel, programs SRC/DST/CONFIG/VALID over single-beat AXI
// writes, waits for the DMA interrupt, clears it and reports completion.
//   clk_i, rst_ni                      clock, async active-low reset
//   ch_req_i/src/dst/cfg               per-channel descriptors (flattened)
//   ch_ack_o, ch_done_o, ch_err_o      per-channel one-cycle pulses
//   busy_o, cur_ch_o                   status
//   m_aw*, m_w*, m_b*                  AXI write master to the DMA slave
//   dma_irq_i, dma_clear_irq_o         DMA interrupt and its clear
//
// state       | meaning
// ST_IDLE     | waiting for a request; grant, capture descriptor, ack
// ST_WR_REQ   | AW and W valid, each dropped after its own handshake
// ST_WR_RESP  | waiting for B; error aborts, else next register or wait
// ST_WAIT_IRQ | job running in the DMA controller
// ST_CLEAR    | clearing the interrupt until it reads back low

module dma_sched
    import dma_sched_pkg::*;
#(
    parameter int                      NUM_CH   = 4,
    parameter logic [`ADDR_WIDTH-1:0]  DMA_BASE = '0,
    parameter int                      AXI_ID   = 0,
    localparam int                     CH_W     = $clog2(NUM_CH)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,

    input  logic [NUM_CH-1:0]         ch_req_i,
    input  logic [NUM_CH*AW-1:0]      ch_src_i,
    input  logic [NUM_CH*AW-1:0]      ch_dst_i,
    input  logic [NUM_CH*CFG_W-1:0]   ch_cfg_i,
    output logic [NUM_CH-1:0]         ch_ack_o,
    output logic [NUM_CH-1:0]         ch_done_o,
    output logic [NUM_CH-1:0]         ch_err_o,
    output logic                      busy_o,
    output logic [CH_W-1:0]           cur_ch_o,

    output logic [ID_W-1:0]           m_awid,
    output logic [AW-1:0]             m_awaddr,
    output logic [LEN_W-1:0]          m_awlen,
    output logic [SIZE_W-1:0]         m_awsize,
    output logic [1:0]                m_awburst,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [DATA_W-1:0]         m_wdata,
    output logic [STRB_W-1:0]         m_wstrb,
    output logic                      m_wlast,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    input  logic [ID_W-1:0]           m_bid,
    input  logic [2:0]                m_bresp,
    input  logic                      m_bvalid,
    output logic                      m_bready,

    input  logic                      dma_irq_i,
    output logic                      dma_clear_irq_o
);

    state_e               state_q, state_nxt;
    reg_idx_e             reg_q, reg_nxt;
    logic                 aw_pend_q, aw_pend_nxt;
    logic                 w_pend_q, w_pend_nxt;
    logic [NUM_CH-1:0]    own_q;
    logic [NUM_CH-1:0]    ack_q, ack_nxt;
    logic [NUM_CH-1:0]    done_q, done_nxt;
    logic [NUM_CH-1:0]    err_q, err_nxt;
    logic [AW-1:0]        src_q, dst_q;
    logic [CFG_W-1:0]     cfg_q;
    logic [CH_W-1:0]      cur_q;
    logic [DATA_W-1:0]    cfg_word;

    logic [NUM_CH-1:0]    gnt;
    logic [CH_W-1:0]      gnt_idx;
    logic                 gnt_valid;
    logic                 advance;
    logic                 aw_done, w_done;
    logic                 unused_bid;

    // B id is not checked: there is only ever one write outstanding.
    assign unused_bid = ^m_bid;

    rr_arbiter #(.N(NUM_CH)) u_arb (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req       (ch_req_i),
        .advance   (advance),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always_comb begin
        state_nxt   = state_q;
        reg_nxt     = reg_q;
        aw_pend_nxt = aw_pend_q;
        w_pend_nxt  = w_pend_q;
        ack_nxt     = '0;
        done_nxt    = '0;
        err_nxt     = '0;
        advance     = 1'b0;
        aw_done     = !aw_pend_q || m_awready;
        w_done      = !w_pend_q || m_wready;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    advance     = 1'b1;
                    ack_nxt     = gnt;
                    reg_nxt     = REG_SRC;
                    aw_pend_nxt = 1'b1;
                    w_pend_nxt  = 1'b1;
                    state_nxt   = ST_WR_REQ;
                end
            end
            ST_WR_REQ: begin
                if (m_awready) aw_pend_nxt = 1'b0;
                if (m_wready)  w_pend_nxt  = 1'b0;
                if (aw_done && w_done) state_nxt = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                if (m_bvalid) begin
                    if (m_bresp != 3'b000) begin
                        done_nxt  = own_q;
                        err_nxt   = own_q;
                        state_nxt = ST_IDLE;
                    end else if (reg_q != REG_VALID) begin
                        reg_nxt     = reg_idx_e'(reg_q + 2'd1);
                        aw_pend_nxt = 1'b1;
                        w_pend_nxt  = 1'b1;
                        state_nxt   = ST_WR_REQ;
                    end else begin
                        state_nxt = ST_WAIT_IRQ;
                    end
                end
            end
            ST_WAIT_IRQ: begin
                if (dma_irq_i) state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (!dma_irq_i) begin
                    done_nxt  = own_q;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            reg_q     <= REG_SRC;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            own_q     <= '0;
            ack_q     <= '0;
            done_q    <= '0;
            err_q     <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            cfg_q     <= '0;
            cur_q     <= '0;
        end else begin
            state_q   <= state_nxt;
            reg_q     <= reg_nxt;
            aw_pend_q <= aw_pend_nxt;
            w_pend_q  <= w_pend_nxt;
            ack_q     <= ack_nxt;
            done_q    <= done_nxt;
            err_q     <= err_nxt;
            if (advance) begin
                own_q <= gnt;
                cur_q <= gnt_idx;
                src_q <= ch_src_i[gnt_idx*AW +: AW];
                dst_q <= ch_dst_i[gnt_idx*AW +: AW];
                cfg_q <= ch_cfg_i[gnt_idx*CFG_W +: CFG_W];
            end
        end
    end

    always_comb begin
        cfg_word = '0;
        cfg_word[CFG_BURST_MSB:CFG_BURST_LSB] = cfg_q[CFG_BURST_MSB:CFG_BURST_LSB];
        cfg_word[CFG_SIZE_MSB:CFG_SIZE_LSB]   = cfg_q[CFG_SIZE_MSB:CFG_SIZE_LSB];
        cfg_word[CFG_LEN_MSB:CFG_LEN_LSB]     = cfg_q[CFG_LEN_MSB:CFG_LEN_LSB];
    end

    // Payload fields are forced to zero while their valid is low so the
    // whole port reads zero when idle; reg_q only moves between writes, so
    // the payload is stable for as long as valid is high.
    always_comb begin
        m_wdata = '0;
        if (w_pend_q) begin
            case (reg_q)
                REG_SRC: m_wdata = DATA_W'(src_q);
                REG_DST: m_wdata = DATA_W'(dst_q);
                REG_CFG: m_wdata = cfg_word;
                default: m_wdata = 32'h1;
            endcase
        end
    end

    assign m_awvalid = aw_pend_q;
    assign m_awaddr  = aw_pend_q ? DMA_BASE + reg_offset(reg_q) : '0;
    assign m_awid    = aw_pend_q ? ID_W'(AXI_ID) : '0;
    assign m_awlen   = '0;
    assign m_awsize  = aw_pend_q ? AXI_SIZE_4B : '0;
    assign m_awburst = aw_pend_q ? AXI_BURST_INCR : 2'b00;
    assign m_wvalid  = w_pend_q;
    assign m_wstrb   = w_pend_q ? '1 : '0;
    assign m_wlast   = w_pend_q;
    assign m_bready  = (state_q == ST_WR_RESP);

    assign dma_clear_irq_o = (state_q == ST_CLEAR);
    assign busy_o          = (state_q != ST_IDLE);
    assign cur_ch_o        = cur_q;
    assign ch_ack_o        = ack_q;
    assign ch_done_o       = done_q;
    assign ch_err_o        = err_q;

endmodule
